ram_write_sched: RTL

RAM_WRITE_SCHED -- requirements
Module: ram_write_sched

---
 rtl/ram_sched_pkg.sv | 23 ++
 rtl/ram_write_sched_if.sv | 37 +++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/ram_write_sched.sv | 90 +++++++++
 4 files changed

// File: rtl/ram_sched_pkg.sv
// Shared types and defaults for the RAM write scheduler.
package ram_sched_pkg;

  localparam int unsigned ADDR_W_DEF     = 14;
  localparam int unsigned DATA_W_DEF     = 64;
  localparam int unsigned BE_W_DEF       = 8;
  localparam int unsigned GAP_CYCLES_DEF = 10;

  // Word address 0 is reserved and never written.
  localparam int unsigned RSVD_ADDR = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Gap counter width: ceil(log2(gap+1)), at least one bit.
  function automatic int unsigned gap_cnt_w(input int unsigned gap);
    return (gap < 1) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/ram_write_sched_if.sv
// Request/RAM-write bundle between requesters and the scheduler.
interface ram_write_sched_if #(
  parameter int unsigned ADDR_W = ram_sched_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = ram_sched_pkg::DATA_W_DEF,
  parameter int unsigned BE_W   = ram_sched_pkg::BE_W_DEF
) ();

  logic              i_enable;
  logic [1:0]        i_req_valid;
  logic [DATA_W-1:0] i_req_data0;
  logic [DATA_W-1:0] i_req_data1;
  logic [BE_W-1:0]   i_req_be0;
  logic [BE_W-1:0]   i_req_be1;
  logic [1:0]        o_req_ready;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_data;
  logic [BE_W-1:0]   o_ram_be;
  logic              o_ram_wren;
  logic              o_grant_id;
  logic              o_wrap;
  logic              o_busy;

  // Requester / RAM side.
  modport master (
    output i_enable, i_req_valid, i_req_data0, i_req_data1, i_req_be0, i_req_be1,
    input  o_req_ready, o_ram_addr, o_ram_data, o_ram_be, o_ram_wren,
    input  o_grant_id, o_wrap, o_busy
  );

  // Scheduler side.
  modport slave (
    input  i_enable, i_req_valid, i_req_data0, i_req_data1, i_req_be0, i_req_be1,
    output o_req_ready, o_ram_addr, o_ram_data, o_ram_be, o_ram_wren,
    output o_grant_id, o_wrap, o_busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last winner.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_id;

  // Lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_id ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember the winner of each accepted transfer; reset favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= 1'b1;
    end else if (advance) begin
      last_id <= grant[1];
    end
  end

endmodule

// File: rtl/ram_write_sched.sv
// Schedules writes from two requesters into a RAM with an enforced idle gap.
module ram_write_sched #(
  parameter int unsigned ADDR_W     = ram_sched_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W     = ram_sched_pkg::DATA_W_DEF,
  parameter int unsigned BE_W       = ram_sched_pkg::BE_W_DEF,
  parameter int unsigned GAP_CYCLES = ram_sched_pkg::GAP_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ram_write_sched_if.slave bus
);

  import ram_sched_pkg::*;

  localparam int unsigned       CNT_W      = gap_cnt_w(GAP_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(RSVD_ADDR + 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] gap_cnt;
  logic [1:0]       grant;
  logic             accept_window;
  logic             xfer;
  logic             xfer_id;

  rr_arbiter2 u_arb (
    .clk     (i_clk),
    .rst     (i_rst),
    .req     (bus.i_req_valid),
    .advance (xfer),
    .grant   (grant)
  );

  // Ready only for the arbiter's pick, only while idle and enabled.
  assign accept_window   = (state == ST_IDLE) && bus.i_enable;
  assign bus.o_req_ready = accept_window ? grant : 2'b00;
  assign xfer            = |(bus.i_req_valid & bus.o_req_ready);
  assign xfer_id         = bus.o_req_ready[1];
  assign bus.o_busy      = (state != ST_IDLE);

  // Sequencer: accept, one-cycle write strobe, then a fixed idle gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      gap_cnt        <= '0;
      bus.o_ram_wren <= 1'b0;
      bus.o_ram_addr <= '0;
      bus.o_ram_data <= '0;
      bus.o_ram_be   <= '0;
      bus.o_grant_id <= 1'b0;
      bus.o_wrap     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            state          <= ST_WRITE;
            bus.o_ram_wren <= 1'b1;
            bus.o_grant_id <= xfer_id;
            bus.o_ram_data <= xfer_id ? bus.i_req_data1 : bus.i_req_data0;
            bus.o_ram_be   <= xfer_id ? bus.i_req_be1 : bus.i_req_be0;
            // Skip the reserved address when the pointer rolls over.
            if (bus.o_ram_addr == ADDR_MAX) begin
              bus.o_ram_addr <= ADDR_FIRST;
              bus.o_wrap     <= 1'b1;
            end else begin
              bus.o_ram_addr <= bus.o_ram_addr + ADDR_W'(1);
              bus.o_wrap     <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          state          <= ST_GAP;
          gap_cnt        <= '0;
          bus.o_ram_wren <= 1'b0;
          bus.o_wrap     <= 1'b0;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
